// File: rtl/rv_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rv_ctrl_pkg
// Shared definitions for the RV32I multi-cycle control unit:
//   - FSM state encodings (debug-visible on the state port)
//   - RV32I major opcode constants
//   - write-back and PC-source select encodings
//   - instruction-class enum produced by rv_ctrl_opclass
//   - ALU operand-select helpers keyed on instruction class
// -----------------------------------------------------------------------------
package rv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd7
    } state_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10,
        WB_IMM = 2'b11
    } wb_sel_e;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'b00,
        PC_IMM   = 2'b01,
        PC_JALR  = 2'b10
    } pc_sel_e;

    typedef enum logic [3:0] {
        CLS_ALU,
        CLS_IMM,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_LUI,
        CLS_AUIPC,
        CLS_FENCE,
        CLS_SYSTEM,
        CLS_ILLEGAL
    } iclass_e;

    // ALU operand A takes the PC only for PC-relative target/result forms.
    function automatic logic cls_a_is_pc(input iclass_e c);
        return (c == CLS_JAL) || (c == CLS_AUIPC);
    endfunction

    // ALU operand B takes the immediate for every class that carries one
    // through the ALU (address generation, OP-IMM, PC-relative).
    function automatic logic cls_b_is_imm(input iclass_e c);
        return (c == CLS_IMM) || (c == CLS_LOAD) || (c == CLS_STORE) ||
               (c == CLS_JALR) || (c == CLS_JAL) || (c == CLS_AUIPC);
    endfunction

endpackage

// File: rtl/rv_ctrl_opclass.sv
// -----------------------------------------------------------------------------
// rv_ctrl_opclass
// Purely combinational opcode classifier.
// Ports:
//   i_opcode [6:0]  major opcode from the instruction register
//   i_funct3 [2:0]  funct3 field, used only to split SYSTEM
//   o_class         instruction class (iclass_e)
//   o_halt          SYSTEM with funct3=000 (ECALL/EBREAK)
// -----------------------------------------------------------------------------
module rv_ctrl_opclass
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    output iclass_e    o_class,
    output logic       o_halt
);

    always_comb begin
        o_class = CLS_ILLEGAL;
        o_halt  = 1'b0;
        case (i_opcode)
            OPC_OP:     o_class = CLS_ALU;
            OPC_OPIMM:  o_class = CLS_IMM;
            OPC_LOAD:   o_class = CLS_LOAD;
            OPC_STORE:  o_class = CLS_STORE;
            OPC_BRANCH: o_class = CLS_BRANCH;
            OPC_JAL:    o_class = CLS_JAL;
            OPC_JALR:   o_class = CLS_JALR;
            OPC_LUI:    o_class = CLS_LUI;
            OPC_AUIPC:  o_class = CLS_AUIPC;
            OPC_FENCE:  o_class = CLS_FENCE;
            OPC_SYSTEM: begin
                o_class = CLS_SYSTEM;
                o_halt  = (i_funct3 == 3'b000);
            end
            default:    o_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/rv_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// rv_ctrl_fsm
// Multi-cycle control unit for the RV32I core: FETCH -> DECODE -> EXEC ->
// [MEM] -> [WB] -> FETCH, one instruction in flight. TRAP is absorbing.
// Optional feature macro: RV_CTRL_TIMEOUT_EN (memory-request wait timeout).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   opcode, funct3      decoder fields (from the instruction register)
//   rd_valid            instruction writes rd
//   br_taken            branch comparator result, meaningful in EXEC
//   imem_req/imem_ack   instruction fetch handshake, ir_we loads the IR
//   dmem_req/dmem_we/dmem_ack  data memory handshake
//   alu_a_sel, alu_b_sel  ALU operand selects (0=rs1/rs2, 1=PC/imm)
//   rf_we, wb_sel       register write enable and write-back source
//   pc_we, pc_sel       PC update enable and next-PC source
//   illegal, halted     sticky trap causes
//   state               current FSM state (debug)
// -----------------------------------------------------------------------------
module rv_ctrl_fsm
    import rv_ctrl_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 255,
    parameter logic [2:0] RESET_STATE    = 3'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       rd_valid,
    input  logic       br_taken,
    output logic       imem_req,
    input  logic       imem_ack,
    output logic       ir_we,
    output logic       dmem_req,
    output logic       dmem_we,
    input  logic       dmem_ack,
    output logic       alu_a_sel,
    output logic       alu_b_sel,
    output logic       rf_we,
    output logic [1:0] wb_sel,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic       illegal,
    output logic       halted,
    output logic [2:0] state
);

    // The wait counter is 8 bits wide, so the limit must fit in it.
    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
        $error("rv_ctrl_fsm: TIMEOUT_CYCLES must be in 1..255");
    end

    state_e  r_state;
    iclass_e r_class;
    logic    r_illegal;
    logic    r_halted;
    iclass_e w_class;
    logic    w_halt;

    rv_ctrl_opclass u_opclass (
        .i_opcode (opcode),
        .i_funct3 (funct3),
        .o_class  (w_class),
        .o_halt   (w_halt)
    );

`ifdef RV_CTRL_TIMEOUT_EN
    logic [7:0] r_wait_cnt;
    logic       w_req_wait;
    logic       w_tmo;

    assign w_req_wait = ((r_state == ST_FETCH) && !imem_ack) ||
                        ((r_state == ST_MEM)   && !dmem_ack);
    // Trips on the TIMEOUT_CYCLES-th consecutive request cycle without ack.
    assign w_tmo = w_req_wait && (r_wait_cnt == 8'(TIMEOUT_CYCLES - 1));

    // Every path into FETCH or MEM leaves a non-waiting cycle behind it,
    // so clearing whenever no wait is in progress clears on entry.
    always_ff @(posedge clk) begin
        if (rst || !w_req_wait) begin
            r_wait_cnt <= 8'd0;
        end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= state_e'(RESET_STATE);
            r_class   <= CLS_ILLEGAL;
            r_illegal <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (imem_ack) begin
                        r_state <= ST_DECODE;
`ifdef RV_CTRL_TIMEOUT_EN
                    end else if (w_tmo) begin
                        r_state   <= ST_TRAP;
                        r_illegal <= 1'b1;
`endif
                    end
                end
                ST_DECODE: begin
                    r_class <= w_class;
                    if (w_class == CLS_ILLEGAL) begin
                        r_state   <= ST_TRAP;
                        r_illegal <= 1'b1;
                    end else if (w_halt) begin
                        r_state  <= ST_TRAP;
                        r_halted <= 1'b1;
                    end else begin
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (r_class)
                        CLS_BRANCH, CLS_FENCE, CLS_SYSTEM: r_state <= ST_FETCH;
                        CLS_LOAD, CLS_STORE:               r_state <= ST_MEM;
                        default:                           r_state <= ST_WB;
                    endcase
                end
                ST_MEM: begin
                    if (dmem_ack) begin
                        r_state <= (r_class == CLS_LOAD) ? ST_WB : ST_FETCH;
`ifdef RV_CTRL_TIMEOUT_EN
                    end else if (w_tmo) begin
                        r_state   <= ST_TRAP;
                        r_illegal <= 1'b1;
`endif
                    end
                end
                ST_WB:   r_state <= ST_FETCH;
                ST_TRAP: r_state <= ST_TRAP;
                default: r_state <= ST_TRAP;
            endcase
        end
    end

    // Strobes decode from the registered state; ir_we and the store-completion
    // pc_we must also follow the same-cycle ack, so this block stays
    // combinational rather than adding a cycle to every handshake.
    always_comb begin
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        alu_a_sel = 1'b0;
        alu_b_sel = 1'b0;
        rf_we     = 1'b0;
        wb_sel    = WB_ALU;
        pc_we     = 1'b0;
        pc_sel    = PC_PLUS4;
        case (r_state)
            ST_FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ack;
            end
            ST_EXEC: begin
                alu_a_sel = cls_a_is_pc(r_class);
                alu_b_sel = cls_b_is_imm(r_class);
                if (r_class == CLS_BRANCH) begin
                    pc_we  = 1'b1;
                    pc_sel = br_taken ? PC_IMM : PC_PLUS4;
                end else if ((r_class == CLS_FENCE) || (r_class == CLS_SYSTEM)) begin
                    pc_we = 1'b1;
                end
            end
            ST_MEM: begin
                alu_a_sel = cls_a_is_pc(r_class);
                alu_b_sel = cls_b_is_imm(r_class);
                dmem_req  = 1'b1;
                dmem_we   = (r_class == CLS_STORE);
                pc_we     = (r_class == CLS_STORE) && dmem_ack;
            end
            ST_WB: begin
                // Selects held so a combinational ALU result stays valid.
                alu_a_sel = cls_a_is_pc(r_class);
                alu_b_sel = cls_b_is_imm(r_class);
                rf_we     = rd_valid;
                pc_we     = 1'b1;
                case (r_class)
                    CLS_LOAD:          wb_sel = WB_MEM;
                    CLS_JAL, CLS_JALR: wb_sel = WB_PC4;
                    CLS_LUI:           wb_sel = WB_IMM;
                    default:           wb_sel = WB_ALU;
                endcase
                case (r_class)
                    CLS_JAL:  pc_sel = PC_IMM;
                    CLS_JALR: pc_sel = PC_JALR;
                    default:  pc_sel = PC_PLUS4;
                endcase
            end
            default: ;
        endcase
    end

    assign illegal = r_illegal;
    assign halted  = r_halted;
    assign state   = r_state;

endmodule

// File: tb/tb_rv_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_rv_ctrl_fsm
// Cycle-by-cycle directed vectors for rv_ctrl_fsm plus hand-written
// request-wait sequences (timeout when RV_CTRL_TIMEOUT_EN is defined,
// indefinite wait otherwise).
// -----------------------------------------------------------------------------
module tb_rv_ctrl_fsm;

`ifdef RV_CTRL_TIMEOUT_EN
    localparam int TB_TMO = 4;
`else
    localparam int TB_TMO = 255;
`endif

    localparam logic [31:0] I_ADDI  = 32'h00500093;
    localparam logic [31:0] I_LW    = 32'h0000A103;
    localparam logic [31:0] I_BEQ   = 32'h00208463;
    localparam logic [31:0] I_SW    = 32'h0020A223;
    localparam logic [31:0] I_JAL   = 32'h008000EF;
    localparam logic [31:0] I_JALR  = 32'h000080E7;
    localparam logic [31:0] I_LUI   = 32'h123450B7;
    localparam logic [31:0] I_AUIPC = 32'h00000097;
    localparam logic [31:0] I_FENCE = 32'h0000000F;
    localparam logic [31:0] I_CSR   = 32'h34011073;
    localparam logic [31:0] I_BAD   = 32'hFFFFFFFF;
    localparam logic [31:0] I_ECALL = 32'h00000073;

    typedef struct packed {
        logic [2:0] st;
        logic       ireq;
        logic       irwe;
        logic       dreq;
        logic       dwe;
        logic       a;
        logic       b;
        logic       rfwe;
        logic [1:0] wb;
        logic       pcwe;
        logic [1:0] pcs;
        logic       ill;
        logic       hlt;
    } out_t;

    typedef struct packed {
        logic        rst;
        logic [31:0] ins;
        logic        rdv;
        logic        brt;
        logic        iack;
        logic        dack;
        out_t        exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       rd_valid, br_taken, imem_ack, dmem_ack;
    logic       imem_req, ir_we, dmem_req, dmem_we, alu_a_sel, alu_b_sel;
    logic       rf_we, pc_we, illegal, halted;
    logic [1:0] wb_sel, pc_sel;
    logic [2:0] state;

    out_t got;
    assign got = {state, imem_req, ir_we, dmem_req, dmem_we, alu_a_sel, alu_b_sel,
                  rf_we, wb_sel, pc_we, pc_sel, illegal, halted};

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    rv_ctrl_fsm #(
        .TIMEOUT_CYCLES (TB_TMO),
        .RESET_STATE    (3'd0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .funct3    (funct3),
        .rd_valid  (rd_valid),
        .br_taken  (br_taken),
        .imem_req  (imem_req),
        .imem_ack  (imem_ack),
        .ir_we     (ir_we),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .dmem_ack  (dmem_ack),
        .alu_a_sel (alu_a_sel),
        .alu_b_sel (alu_b_sel),
        .rf_we     (rf_we),
        .wb_sel    (wb_sel),
        .pc_we     (pc_we),
        .pc_sel    (pc_sel),
        .illegal   (illegal),
        .halted    (halted),
        .state     (state)
    );

    // Argument order: state, imem_req, ir_we, dmem_req, dmem_we, alu_a, alu_b,
    // rf_we, wb_sel, pc_we, pc_sel, illegal, halted.
    function automatic out_t E(input logic [2:0] st, input logic ireq, irwe, dreq, dwe,
                               input logic a, b, rfwe, input logic [1:0] wb,
                               input logic pcwe, input logic [1:0] pcs,
                               input logic ill, hlt);
        out_t o;
        o = {st, ireq, irwe, dreq, dwe, a, b, rfwe, wb, pcwe, pcs, ill, hlt};
        return o;
    endfunction

    task automatic add(input logic r, input logic [31:0] ins, input logic rdv, brt,
                       input logic iack, dack, input out_t e);
        vec_t v;
        v.rst = r; v.ins = ins; v.rdv = rdv; v.brt = brt;
        v.iack = iack; v.dack = dack; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic r, input logic [31:0] ins, input logic rdv, brt,
                         input logic iack, dack);
        rst      = r;
        opcode   = ins[6:0];
        funct3   = ins[14:12];
        rd_valid = rdv;
        br_taken = brt;
        imem_ack = iack;
        dmem_ack = dack;
    endtask

    task automatic check(input string name, input out_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b required %b (st,ireq,irwe,dreq,dwe,a,b,rfwe,wb,pcwe,pcs,ill,hlt)",
                     name, got, exp);
        end
    endtask

    initial begin
        // Reset state
        add(1, 32'h0,   0, 0, 0, 0, E(0,1,0,0,0,0,0,0,2'b00,0,2'b00,0,0));
        // OP-IMM, zero-wait fetch: 4 cycles
        add(0, I_ADDI,  1, 0, 1, 0, E(0,1,1,0,0,0,0,0,2'b00,0,2'b00,0,0));
        add(0, I_ADDI,  1, 0, 0, 0, E(1,0,0,0,0,0,0,0,2'b00,0,2'b00,0,0));
        add(0, I_ADDI,  1, 0, 0, 0, E(2,0,0,0,0,0,1,0,2'b00,0,2'b00,0,0));
        add(0, I_ADDI,  1, 0, 0, 0, E(4,0,0,0,0,0,1,1,2'b00,1,2'b00,0,0));
        // LOAD, dmem_ack delayed 3 cycles: 8 cycles
        add(0, I_LW,    1, 0, 1, 0, E(0,1,1,0,0,0,0,0,2'b00,0,2'b00,0,0));
        add(0, I_LW,    1, 0, 0, 0, E(1,0,0,0,0,0,0,0,2'b00,0,2'b00,0,0));
        add(0, I_LW,    1, 0, 0, 0, E(2,0,0,0,0,0,1,0,2'b00,0,2'b00,0,0));
        add(0, I_LW,    1, 0, 0, 0, E(3,0,0,1,0,0,1,0,2'b00,0,2'b00,0,0));
        add(0, I_LW,    1, 0, 0, 0, E(3,0,0,1,0,0,1,0,2'b00,0,2'b00,0,0));
        add(0, I_LW,    1, 0, 0, 0, E(3,0,0,1,0,0,1,0,2'b00,0,2'b00,0,0));
        add(0, I_LW,    1, 0, 0, 1, E(3,0,0,1,0,0,1,0,2'b00,0,2'b00,0,0));
        add(0, I_LW,    1, 0, 0, 0, E(4,0,0,0,0,0,1,1,2'b01,1,2'b00,0,0));
        // BRANCH taken, spurious dmem_ack during fetch
        add(0, I_BEQ,   0, 1, 1, 1, E(0,1,1,0,0,0,0,0,2'b00,0,2'b00,0,0));
        add(0, I_BEQ,   0, 1, 0, 0, E(1,0,0,0,0,0,0,0,2'b00,0,2'b00,0,0));
        add(0, I_BEQ,   0, 1, 0, 0, E(2,0,0,0,0,0,0,0,2'b00,1,2'b01,0,0));
        // BRANCH not taken, one fetch wait cycle
        add(0, I_BEQ,   0, 0, 0, 0, E(0,1,0,0,0,0,0,0,2'b00,0,2'b00,0,0));
        add(0, I_BEQ,   0, 0, 1, 0, E(0,1,1,0,0,0,0,0,2'b00,0,2'b00,0,0));
        add(0, I_BEQ,   0, 0, 0, 0, E(1,0,0,0,0,0,0,0,2'b00,0,2'b00,0,0));
        add(0, I_BEQ,   0, 0, 0, 0, E(2,0,0,0,0,0,0,0,2'b00,1,2'b00,0,0));
        // STORE, zero-wait: 4 cycles
        add(0, I_SW,    0, 0, 1, 0, E(0,1,1,0,0,0,0,0,2'b00,0,2'b00,0,0));
        add(0, I_SW,    0, 0, 0, 0, E(1,0,0,0,0,0,0,0,2'b00,0,2'b00,0,0));
        add(0, I_SW,    0, 0, 0, 0, E(2,0,0,0,0,0,1,0,2'b00,0,2'b00,0,0));
        add(0, I_SW,    0, 0, 0, 1, E(3,0,0,1,1,0,1,0,2'b00,1,2'b00,0,0));
        // JAL
        add(0, I_JAL,   1, 0, 1, 0, E(0,1,1,0,0,0,0,0,2'b00,0,2'b00,0,0));
        add(0, I_JAL,   1, 0, 0, 0, E(1,0,0,0,0,0,0,0,2'b00,0,2'b00,0,0));
        add(0, I_JAL,   1, 0, 0, 0, E(2,0,0,0,0,1,1,0,2'b00,0,2'b00,0,0));
        add(0, I_JAL,   1, 0, 0, 0, E(4,0,0,0,0,1,1,1,2'b10,1,2'b01,0,0));
        // JALR
        add(0, I_JALR,  1, 0, 1, 0, E(0,1,1,0,0,0,0,0,2'b00,0,2'b00,0,0));
        add(0, I_JALR,  1, 0, 0, 0, E(1,0,0,0,0,0,0,0,2'b00,0,2'b00,0,0));
        add(0, I_JALR,  1, 0, 0, 0, E(2,0,0,0,0,0,1,0,2'b00,0,2'b00,0,0));
        add(0, I_JALR,  1, 0, 0, 0, E(4,0,0,0,0,0,1,1,2'b10,1,2'b10,0,0));
        // LUI
        add(0, I_LUI,   1, 0, 1, 0, E(0,1,1,0,0,0,0,0,2'b00,0,2'b00,0,0));
        add(0, I_LUI,   1, 0, 0, 0, E(1,0,0,0,0,0,0,0,2'b00,0,2'b00,0,0));
        add(0, I_LUI,   1, 0, 0, 0, E(2,0,0,0,0,0,0,0,2'b00,0,2'b00,0,0));
        add(0, I_LUI,   1, 0, 0, 0, E(4,0,0,0,0,0,0,1,2'b11,1,2'b00,0,0));
        // AUIPC
        add(0, I_AUIPC, 1, 0, 1, 0, E(0,1,1,0,0,0,0,0,2'b00,0,2'b00,0,0));
        add(0, I_AUIPC, 1, 0, 0, 0, E(1,0,0,0,0,0,0,0,2'b00,0,2'b00,0,0));
        add(0, I_AUIPC, 1, 0, 0, 0, E(2,0,0,0,0,1,1,0,2'b00,0,2'b00,0,0));
        add(0, I_AUIPC, 1, 0, 0, 0, E(4,0,0,0,0,1,1,1,2'b00,1,2'b00,0,0));
        // FENCE: 3 cycles
        add(0, I_FENCE, 0, 0, 1, 0, E(0,1,1,0,0,0,0,0,2'b00,0,2'b00,0,0));
        add(0, I_FENCE, 0, 0, 0, 0, E(1,0,0,0,0,0,0,0,2'b00,0,2'b00,0,0));
        add(0, I_FENCE, 0, 0, 0, 0, E(2,0,0,0,0,0,0,0,2'b00,1,2'b00,0,0));
        // Non-halting SYSTEM (CSR) runs as a nop, no rf_we
        add(0, I_CSR,   1, 0, 1, 0, E(0,1,1,0,0,0,0,0,2'b00,0,2'b00,0,0));
        add(0, I_CSR,   1, 0, 0, 0, E(1,0,0,0,0,0,0,0,2'b00,0,2'b00,0,0));
        add(0, I_CSR,   1, 0, 0, 0, E(2,0,0,0,0,0,0,0,2'b00,1,2'b00,0,0));
        // Illegal opcode -> TRAP at cycle 2, sticky through acks, cleared by rst
        add(0, I_BAD,   1, 0, 1, 0, E(0,1,1,0,0,0,0,0,2'b00,0,2'b00,0,0));
        add(0, I_BAD,   1, 0, 0, 0, E(1,0,0,0,0,0,0,0,2'b00,0,2'b00,0,0));
        add(0, I_BAD,   1, 0, 1, 0, E(7,0,0,0,0,0,0,0,2'b00,0,2'b00,1,0));
        add(0, I_BAD,   1, 0, 1, 1, E(7,0,0,0,0,0,0,0,2'b00,0,2'b00,1,0));
        add(1, I_BAD,   1, 0, 0, 0, E(7,0,0,0,0,0,0,0,2'b00,0,2'b00,1,0));
        // ECALL -> TRAP with halted, cleared by rst
        add(0, I_ECALL, 0, 0, 1, 0, E(0,1,1,0,0,0,0,0,2'b00,0,2'b00,0,0));
        add(0, I_ECALL, 0, 0, 0, 0, E(1,0,0,0,0,0,0,0,2'b00,0,2'b00,0,0));
        add(0, I_ECALL, 0, 0, 0, 0, E(7,0,0,0,0,0,0,0,2'b00,0,2'b00,0,1));
        add(1, I_ECALL, 0, 0, 0, 0, E(7,0,0,0,0,0,0,0,2'b00,0,2'b00,0,1));
        // STORE with rst during MEM wait: abandoned, no pc_we
        add(0, I_SW,    0, 0, 1, 0, E(0,1,1,0,0,0,0,0,2'b00,0,2'b00,0,0));
        add(0, I_SW,    0, 0, 0, 0, E(1,0,0,0,0,0,0,0,2'b00,0,2'b00,0,0));
        add(0, I_SW,    0, 0, 0, 0, E(2,0,0,0,0,0,1,0,2'b00,0,2'b00,0,0));
        add(0, I_SW,    0, 0, 0, 0, E(3,0,0,1,1,0,1,0,2'b00,0,2'b00,0,0));
        add(1, I_SW,    0, 0, 0, 0, E(3,0,0,1,1,0,1,0,2'b00,0,2'b00,0,0));
        add(0, I_SW,    0, 0, 0, 1, E(0,1,0,0,0,0,0,0,2'b00,0,2'b00,0,0));

        drive(1, 32'h0, 0, 0, 0, 0);
        @(posedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].ins, tbl[i].rdv, tbl[i].brt, tbl[i].iack, tbl[i].dack);
            #1;
            check($sformatf("row%0d", i), tbl[i].exp);
        end

        // Request wait with imem_ack withheld after a fresh reset.
        @(negedge clk);
        drive(1, I_ADDI, 1, 0, 0, 0);
`ifdef RV_CTRL_TIMEOUT_EN
        for (int k = 0; k < TB_TMO; k++) begin
            @(negedge clk);
            drive(0, I_ADDI, 1, 0, 0, 0);
            #1;
            check($sformatf("tmo_wait%0d", k), E(0,1,0,0,0,0,0,0,2'b00,0,2'b00,0,0));
        end
        @(negedge clk);
        #1;
        check("tmo_trap", E(7,0,0,0,0,0,0,0,2'b00,0,2'b00,1,0));
        @(negedge clk);
        drive(0, I_ADDI, 1, 0, 1, 0);
        #1;
        check("tmo_sticky", E(7,0,0,0,0,0,0,0,2'b00,0,2'b00,1,0));
`else
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            drive(0, I_ADDI, 1, 0, 0, 0);
            #1;
            check($sformatf("wait%0d", k), E(0,1,0,0,0,0,0,0,2'b00,0,2'b00,0,0));
        end
        @(negedge clk);
        drive(0, I_ADDI, 1, 0, 1, 0);
        #1;
        check("wait_ack", E(0,1,1,0,0,0,0,0,2'b00,0,2'b00,0,0));
        @(negedge clk);
        drive(0, I_ADDI, 1, 0, 0, 0);
        #1;
        check("wait_decode", E(1,0,0,0,0,0,0,0,2'b00,0,2'b00,0,0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
